// File: rtl/cpu_operand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_operand_pkg
// Purpose  : Shared types and helpers for the operand select stage.
//            - state_e      : occupancy encoding of the 2-entry skid buffer
//            - SRC_*        : canonical source indices into SRC_DATA
//            - negate_op()  : two's-complement negation truncated to width
// Revision : 1.0 - initial release
// ============================================================================
package cpu_operand_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned SRC_REG = 0;
  localparam int unsigned SRC_IMM = 1;
  localparam int unsigned SRC_FWD = 2;
  localparam int unsigned SRC_MEM = 3;

  // Two's-complement negate, wrapping modulo 2^width (width <= 64).
  // 0 maps to 0 and the most negative value maps to itself.
  function automatic logic [63:0] negate_op(input logic [63:0] val,
                                            input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (~val + 64'd1) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : operand_skid_buffer
// Purpose  : Generic 2-entry valid/ready buffer (main + skid register) with a
//            synchronous flush. The main register drives the outputs; the
//            skid register catches the one operand accepted while the
//            consumer stalls, so in_ready can be a pure register.
// Ports    : clk, rst_n           - clock, async active-low reset
//            flush                - drop all buffered entries (priority)
//            in_valid/in_ready    - upstream handshake, in_data payload
//            out_valid/out_ready  - downstream handshake, out_data payload
// Revision : 1.0 - initial release
// ============================================================================
module operand_skid_buffer
  import cpu_operand_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  state_e          state_q, state_d;
  logic [DW-1:0]   main_q,  main_d;
  logic [DW-1:0]   skid_q,  skid_d;
  logic            in_ready_q, in_ready_d;

  logic            acc;
  logic            pop;

  assign acc = in_valid  && in_ready_q;
  assign pop = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (acc && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Ready is computed from the next state so it is a flop output and
    // never sees out_ready combinationally.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

endmodule
`default_nettype wire

// File: rtl/operand_select_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_select_stage
// Purpose  : Selects OPERAND1 for the ALU from NSRC packed sources, optionally
//            negates it (SUB), flags out-of-range selects, and registers the
//            result behind a 2-entry valid/ready skid buffer.
// Ports    : clk, rst_n           - clock, async active-low reset
//            in_valid/in_ready    - decode-side handshake
//            src_data             - NSRC*WIDTH packed sources, k at [k*W +: W]
//            sel, negate          - source index, negate request
//            flush                - discard all buffered operands
//            out_valid/out_ready  - ALU-side handshake
//            operand, sel_err     - result and out-of-range flag
// Revision : 1.0 - initial release
// ============================================================================
module operand_select_stage
  import cpu_operand_pkg::*;
#(
  parameter  int WIDTH = 8,   // 1..64
  parameter  int NSRC  = 4,   // 2..16
  localparam int SELW  = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  negate,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      operand,
  output logic                  sel_err
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] val;
  logic             err;
  logic [WIDTH:0]   buf_out;

  // An index with no matching source leaves raw at zero and raises err;
  // negating zero keeps it zero, so an errored operand is always 0.
  always_comb begin
    raw = '0;
    err = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        raw = src_data[k*WIDTH +: WIDTH];
        err = 1'b0;
      end
    end
    val = negate ? WIDTH'(negate_op(64'(raw), WIDTH)) : raw;
  end

  operand_skid_buffer #(
    .DW (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({val, err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign operand = buf_out[WIDTH:1];
  assign sel_err = buf_out[0];

endmodule
`default_nettype wire

// File: tb/tb_operand_select_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_select_stage
// Purpose  : Directed self-checking bench for operand_select_stage. A default
//            instance (WIDTH=8, NSRC=4) covers select, negate, backpressure,
//            throughput, flush and async reset; a NSRC=3 instance covers the
//            out-of-range select flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_select_stage;

  logic        clk = 1'b0;
  logic        rst_n;

  // NSRC=4 instance
  logic        in_valid, in_ready, negate, flush, out_valid, out_ready, sel_err;
  logic [31:0] src_data;
  logic [1:0]  sel;
  logic [7:0]  operand;

  // NSRC=3 instance
  logic        in_valid3, in_ready3, negate3, flush3, out_valid3, out_ready3, sel_err3;
  logic [23:0] src_data3;
  logic [1:0]  sel3;
  logic [7:0]  operand3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_select_stage #(.WIDTH(8), .NSRC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .sel(sel), .negate(negate), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .operand(operand),
    .sel_err(sel_err)
  );

  operand_select_stage #(.WIDTH(8), .NSRC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .src_data(src_data3), .sel(sel3), .negate(negate3), .flush(flush3),
    .out_valid(out_valid3), .out_ready(out_ready3), .operand(operand3),
    .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; negate = 0; flush = 0; out_ready = 0; sel = 0; src_data = '0;
    in_valid3 = 0; negate3 = 0; flush3 = 0; out_ready3 = 0; sel3 = 0; src_data3 = '0;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_operand",   operand,   8'h00);
    chk("rst_sel_err",   sel_err,   0);
    chk("rst_in_ready",  in_ready,  1);
    rst_n = 1'b1;

    // Single op: select source 1
    src_data = 32'h44332211; sel = 2'd1; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    chk("single_valid",   out_valid, 1);
    chk("single_operand", operand,   8'h22);
    chk("single_err",     sel_err,   0);
    step();
    chk("single_drain",   out_valid, 0);

    // Negate boundaries: k0=05, k1=00, k2=80, k3=7F
    src_data = 32'h7F800005; negate = 1; in_valid = 1; sel = 2'd0;
    step();
    chk("neg_05", operand, 8'hFB);
    sel = 2'd1;
    step();
    chk("neg_00", operand, 8'h00);
    sel = 2'd2;
    step();
    chk("neg_80", operand, 8'h80);
    sel = 2'd3;
    step();
    chk("neg_7f", operand, 8'h81);
    in_valid = 0; negate = 0;
    step();
    chk("neg_drain", out_valid, 0);

    // Backpressure: 01, 02, 03 with the consumer stalled
    out_ready = 0; src_data = 32'h00030201; in_valid = 1; sel = 2'd0;
    step();
    chk("bp_ready1", in_ready, 1);
    chk("bp_op1",    operand,  8'h01);
    sel = 2'd1;
    step();
    chk("bp_ready2", in_ready, 0);
    chk("bp_op2",    operand,  8'h01);
    sel = 2'd2;
    step();
    chk("bp_held_ready", in_ready,  0);
    chk("bp_stable_op",  operand,   8'h01);
    chk("bp_stable_vld", out_valid, 1);
    out_ready = 1;
    step();
    chk("bp_out2",   operand,  8'h02);
    chk("bp_ready3", in_ready, 1);
    step();
    in_valid = 0;
    chk("bp_out3", operand, 8'h03);
    step();
    chk("bp_drain", out_valid, 0);

    // Full throughput: 16 back-to-back with 1-cycle latency
    out_ready = 1; sel = 2'd0; in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      src_data = {24'h0, 8'(8'h10 + i)};
      step();
      chk("tp_valid", out_valid, 1);
      chk("tp_op",    operand,   32'(8'h10 + i));
      chk("tp_ready", in_ready,  1);
    end
    in_valid = 0;
    step();
    chk("tp_drain", out_valid, 0);

    // Range error on the NSRC=3 instance
    src_data3 = 24'h332211; sel3 = 2'd3; in_valid3 = 1; out_ready3 = 1;
    step();
    chk("rng_err_valid", out_valid3, 1);
    chk("rng_err_op",    operand3,   8'h00);
    chk("rng_err_flag",  sel_err3,   1);
    sel3 = 2'd2;
    step();
    chk("rng_ok_op",   operand3, 8'h33);
    chk("rng_ok_flag", sel_err3, 0);
    in_valid3 = 0;
    step();
    chk("rng_drain", out_valid3, 0);

    // Flush from TWO with an accept attempt in the same cycle
    out_ready = 0; sel = 2'd0; in_valid = 1; src_data = 32'h000000AA;
    step();
    src_data = 32'h000000BB;
    step();
    chk("fl_full", in_ready, 0);
    flush = 1; src_data = 32'h000000CC;
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready,  1);
    flush = 0; in_valid = 0;
    step();
    chk("fl_nothing", out_valid, 0);
    in_valid = 1; out_ready = 1; src_data = 32'h000000DD;
    step();
    in_valid = 0;
    chk("fl_resume", operand, 8'hDD);
    step();

    // Async reset mid-cycle from TWO
    out_ready = 0; in_valid = 1; src_data = 32'h000000E1;
    step();
    src_data = 32'h000000E2;
    step();
    chk("ar_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   out_valid, 0);
    chk("ar_operand", operand,   8'h00);
    chk("ar_err",     sel_err,   0);
    chk("ar_ready",   in_ready,  1);
    in_valid = 0;
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_post_valid", out_valid, 0);
    chk("ar_post_ready", in_ready,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_select_stage.md
Name: operand_select_stage

Overview:
- Next-generation operand selector for the datapath, feeding OPERAND1 to the ALU.
- Generalises the 2:1 immediate/non-immediate select to NSRC parametrised sources of WIDTH bits: register file, immediate, forwarded ALU result, memory read data.
- Adds optional two's-complement negation, replacing the separate subtract mux.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the decode stage decouples from ALU stalls (data-cache wait).

Parameters:
- WIDTH, 8, operand bit width.
- NSRC, 4, number of selectable sources (2..16).
- SELW, $clog2(NSRC), width of SEL. Derived; must not be overridden.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset. Asserting low clears all state immediately; deassertion is synchronised upstream.
- IN_VALID  input  1  upstream presents SRC_DATA/SEL/NEGATE this cycle.
- IN_READY  output  1  stage can accept; transfer when IN_VALID && IN_READY.
- SRC_DATA  input  NSRC*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH].
- SEL  input  SELW  source index.
- NEGATE  input  1  1 = output two's complement of the selected source (SUB).
- FLUSH  input  1  synchronous discard of all buffered operands (branch/jump).
- OUT_VALID  output  1  OPERAND is valid.
- OUT_READY  input  1  downstream accepts; transfer when OUT_VALID && OUT_READY.
- OPERAND  output  WIDTH  selected, optionally negated operand.
- SEL_ERR  output  1  travels with OPERAND; 1 = SEL was >= NSRC.

Behaviour:
- Compute (combinational, on accept): raw = SRC_DATA[SEL]. If SEL >= NSRC, raw = 0 and err = 1. val = NEGATE ? (~raw + 1) mod 2^WIDTH : raw.
  - Negation wraps: 0x00 -> 0x00, 0x80 -> 0x80 (WIDTH=8).
- Storage: main register (drives outputs) plus skid register. Each holds {val, err}.
- States: EMPTY (0 entries), ONE (main valid), TWO (main + skid valid). Encoding from package.
- OUT_VALID = (state != EMPTY). OPERAND/SEL_ERR = main contents.
- IN_READY = (state != TWO). It is registered and never combinationally depends on OUT_READY.
- Transitions (acc = IN_VALID && IN_READY, pop = OUT_VALID && OUT_READY):
  - EMPTY: acc -> ONE, main <= new.
  - ONE: acc && !pop -> TWO, skid <= new. acc && pop -> ONE, main <= new. !acc && pop -> EMPTY. Otherwise hold.
  - TWO: pop -> ONE, main <= skid. No accept is possible.
- Latency: accepted operand appears on OPERAND the next cycle when EMPTY, or when ONE with simultaneous pop.
- Throughput: 1 per cycle with OUT_READY held high.
- Ordering: strictly FIFO; no operand is dropped or duplicated.
- Stability: while OUT_VALID && !OUT_READY, OPERAND and SEL_ERR stay stable.
- FLUSH: next state = EMPTY. Any accept or pop in the same cycle is discarded; OUT_VALID = 0 next cycle, IN_READY = 1 next cycle. FLUSH has priority over all other events.
- Reset: asynchronous clear regardless of CLK, including mid-transfer. State = EMPTY, OUT_VALID = 0, OPERAND = 0, SEL_ERR = 0, IN_READY = 1 after the reset edge. Register contents are zeroed.
- Unknowns: no X on any output after reset.
  - An X on SEL while IN_VALID = 0 has no effect.
  - SRC_DATA is sampled only on accept.

Decomposition:
- Package cpu_operand_pkg:
  - state enum/localparams (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2);
  - function negate_op(val, width);
  - constants for source indices: SRC_REG = 0, SRC_IMM = 1, SRC_FWD = 2, SRC_MEM = 3.
- Sub-module operand_skid_buffer: generic WIDTH+1-bit 2-entry valid/ready buffer holding state, main and skid, with FLUSH.
- Top level: the select/negate/range-check logic plus one instance of operand_skid_buffer.

Test Plan:
- Reset then single op: SRC_DATA = {0x44, 0x33, 0x22, 0x11}, SEL = 1, NEGATE = 0, IN_VALID for 1 cycle, OUT_READY = 1 -> next cycle OUT_VALID = 1, OPERAND = 0x22, SEL_ERR = 0; following cycle OUT_VALID = 0.
- Negate boundaries: select 0x05 / 0x00 / 0x80 with NEGATE = 1 -> OPERAND 0xFB / 0x00 / 0x80.
- Backpressure: stream 0x01, 0x02, 0x03 with OUT_READY = 0 -> IN_READY drops after 2 accepts; 0x03 held upstream. Raise OUT_READY -> outputs 0x01, 0x02, 0x03 in order; OPERAND stable while stalled.
- Full throughput: 16 back-to-back ops with OUT_READY = 1 -> 16 outputs on consecutive cycles, 1-cycle latency, IN_READY never low.
- Range error: NSRC = 3, SEL = 3 -> OPERAND = 0x00, SEL_ERR = 1. NSRC = 3, SEL = 2 -> SEL_ERR = 0.
- Flush and reset mid-op: state TWO with IN_VALID = 1, assert FLUSH -> next cycle OUT_VALID = 0, IN_READY = 1, nothing accepted. Repeat with RESET low between edges -> outputs clear immediately without a clock edge.
